bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Parametrised, sequential double-dabble converter from unsigned binary to packed BCD.
- Successor to the fixed 14-bit/4-digit converter. Generalised in input width and digit count.
- Adds a start/busy/done handshake, input capture, overflow detection, and a single-iteration-per-cycle datapath.
- Feeds the seven-segment display path and any other decimal readout.

Parameters:
- BIN_W, 14, input binary width in bits (>=1).
- DIGITS, 4, number of BCD output digits (>=1).
- CNT_W, $clog2(BIN_W+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  conversion request; sampled only in IDLE.
- bin_in  in  BIN_W  unsigned binary operand; captured in the cycle start is accepted.
- busy  out  1  high from the cycle after start is accepted until done; start is ignored while high.
- done  out  1  single-cycle pulse when bcd_out/overflow update.
- bcd_out  out  4*DIGITS  result; digit k at bits [4k+3:4k], digit 0 least significant; held until next done.
- overflow  out  1  bin_in > 10^DIGITS-1; bcd_out then holds the low DIGITS decimal digits.
- digit_blank  out  DIGITS  leading-zero blank mask (see Optional Feature).
- state  out  2  debug view of FSM state.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; bcd_out=0, overflow=0, done=0, busy=0, digit_blank=0; shift register and counter cleared. Takes effect mid-conversion; the partial result is discarded, and no done is issued.
- State encoding: IDLE=2'b00, LOAD=2'b01, CONV=2'b10, DONE=2'b11.
- IDLE: when start=1, capture bin_in into the low bits of a shift register of width 4*DIGITS+BIN_W, upper field zero; go to LOAD.
- LOAD: clear counter, clear overflow accumulator, busy=1; go to CONV.
- CONV, one iteration per cycle:
  - Every BCD digit >4 gets +3 (combinational).
  - Then the whole register shifts left by 1.
  - Any 1 shifted out of the top digit sets the overflow accumulator.
  - The counter increments.
  - After BIN_W iterations, go to DONE.
- DONE: register the upper field into bcd_out and the accumulator into overflow; done=1 for this cycle only; busy=0; go to IDLE.
- Latency: start sampled at edge N gives done high in the cycle after edge N+BIN_W+2. Default is 16 cycles.
- Throughput: one conversion per BIN_W+3 cycles. start held high restarts immediately after DONE.
- start while busy: ignored and not queued. bin_in changes after capture have no effect.
- Arithmetic: the digit add is 4-bit; a post-adjust digit is never >12 before the shift. Overflow is sticky only within one conversion.
- BIN_W < 4*DIGITS is legal; the upper digits are simply zero.

Optional Feature:
- Macro: BIN2BCD_BLANK_EN.
- With macro: digit_blank[k]=1 iff digit k and all higher digits are 0, for k>=1. digit_blank[0] is always 0. Registered with bcd_out at DONE; cleared by reset.
- Without macro: digit_blank tied to 0, and no blanking logic is synthesised.

Decomposition:
- Package bin2bcd_pkg holds:
  - state constants IDLE/LOAD/CONV/DONE;
  - DIGIT_W=4;
  - ADJ_THRESH=4 (adjust when digit > 4);
  - ADJ_ADD=3.
- Sub-module dabble_digit: a combinational 4-bit add-3-if->4 cell, instantiated DIGITS times via generate inside bin2bcd_seq.

Test Plan:
- Defaults, bin_in=9999, start pulse: done exactly 16 cycles after start sample; bcd_out=16'h9999; overflow=0.
- Defaults, bin_in=0: bcd_out=16'h0000, overflow=0. Under BIN2BCD_BLANK_EN: digit_blank=4'b1110. With bin_in=42: bcd_out=16'h0042, digit_blank=4'b1100.
- Defaults, bin_in=16383: bcd_out=16'h6383, overflow=1. Next conversion of 1234: overflow=0, bcd_out=16'h1234.
- Start 5000, then pulse start with bin_in=7 at cycle 5 while busy: exactly one done; bcd_out=16'h5000.
- Start 8765, assert reset_n=0 at cycle 8, release, then convert 321: no done during reset; outputs are 0 during reset; second result is 16'h0321.
- BIN_W=8, DIGITS=3, bin_in=255: done 10 cycles after start; bcd_out=12'h255; overflow=0. Back-to-back with start held high gives a second done 11 cycles later.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bin2bcd_pkg : shared constants and FSM state type for bin2bcd_seq        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package bin2bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd4;
  localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    CONV = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq_dabble_digit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dabble_digit : combinational add-3-if-greater-than-4 BCD cell            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dabble_digit
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] digit_out
);

  // Inputs never exceed 9, so the 4-bit sum tops out at 12 and cannot wrap.
  assign digit_out = (digit_in > ADJ_THRESH) ? (digit_in + ADJ_ADD) : digit_in;

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bin2bcd_seq : sequential double-dabble binary-to-BCD converter           |
// | Optional leading-zero blank mask via BIN2BCD_BLANK_EN.  Rev 1.0          |
// +--------------------------------------------------------------------------+
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4,
  parameter int CNT_W  = $clog2(BIN_W + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic [DIGITS-1:0]     digit_blank,
  output logic [1:0]            state
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;

  state_t             r_state;
  state_t             w_next;
  logic [SR_W-1:0]    r_shift;
  logic [SR_W-1:0]    w_adj;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_acc;
  logic               r_busy;
  logic               r_done;
  logic               r_overflow;
  logic [BCD_W-1:0]   r_bcd;
  logic               w_last;

  assign w_last = (r_cnt == CNT_W'(BIN_W - 1));

  // Binary field passes through untouched; only the BCD digits are adjusted.
  assign w_adj[BIN_W-1:0] = r_shift[BIN_W-1:0];

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      dabble_digit u_cell (
        .digit_in  (r_shift[BIN_W + DIGIT_W*k +: DIGIT_W]),
        .digit_out (w_adj[BIN_W + DIGIT_W*k +: DIGIT_W])
      );
    end
  endgenerate

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD:    w_next = CONV;
      CONV:    if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift    <= '0;
      r_cnt      <= '0;
      r_ovf_acc  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_bcd      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift <= {{BCD_W{1'b0}}, bin_in};
            r_busy  <= 1'b1;
          end
        end
        LOAD: begin
          r_cnt     <= '0;
          r_ovf_acc <= 1'b0;
        end
        CONV: begin
          // A 1 leaving the top digit is a carry into 10^DIGITS.
          r_shift   <= {w_adj[SR_W-2:0], 1'b0};
          r_ovf_acc <= r_ovf_acc | w_adj[SR_W-1];
          r_cnt     <= r_cnt + CNT_W'(1);
        end
        DONE: begin
          r_bcd      <= r_shift[SR_W-1 -: BCD_W];
          r_overflow <= r_ovf_acc;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank;

  always_comb begin
    logic zero_above;
    w_blank    = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (r_shift[BIN_W + DIGIT_W*k +: DIGIT_W] == '0);
      w_blank[k] = zero_above;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             r_blank <= '0;
    else if (r_state == DONE) r_blank <= w_blank;
  end

  assign digit_blank = r_blank;
`else
  assign digit_blank = '0;
`endif

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd_out  = r_bcd;
  assign overflow = r_overflow;
  assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bin2bcd_seq : self-checking bench for bin2bcd_seq (14b/4d and 8b/3d)  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_bin2bcd_seq;

`ifdef BIN2BCD_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        start = 1'b0;
  logic [13:0] bin_in = '0;
  logic        busy, done, ovf;
  logic [15:0] bcd;
  logic [3:0]  blank;
  logic [1:0]  st;

  logic        start2 = 1'b0;
  logic [7:0]  bin2 = '0;
  logic        busy2, done2, ovf2;
  logic [11:0] bcd2;
  logic [2:0]  blank2;
  logic [1:0]  st2;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd), .overflow(ovf),
    .digit_blank(blank), .state(st)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut_s (
    .clk(clk), .reset_n(reset_n), .start(start2), .bin_in(bin2),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2),
    .digit_blank(blank2), .state(st2)
  );

  // Reference: decimal digits of v mod 10^nd, overflow if v >= 10^nd,
  // blank[k] when the retained value is below 10^k.
  function automatic void model(input int v, input int nd, output logic [15:0] e_bcd,
                                output logic e_ovf, output logic [3:0] e_blank);
    int p, r, pk;
    p = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    e_ovf   = (v >= p);
    r       = v % p;
    e_bcd   = '0;
    e_blank = '0;
    pk      = 1;
    for (int k = 0; k < nd; k++) begin
      if (BLANK_ON && k >= 1 && (v % p) < pk) e_blank[k] = 1'b1;
      pk = pk * 10;
    end
    for (int k = 0; k < nd; k++) begin
      e_bcd[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endfunction

  task automatic run_conv(input int v, output int lat);
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'(v);
    @(negedge clk);
    start  = 1'b0;
    bin_in = 14'($urandom);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) break;
    end
    if (!done) lat = -1;
  endtask

  task automatic run_conv2(input int v, output int lat);
    @(negedge clk);
    start2 = 1'b1;
    bin2   = 8'(v);
    @(negedge clk);
    start2 = 1'b0;
    bin2   = 8'($urandom);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (done2) break;
    end
    if (!done2) lat = -1;
  endtask

  task automatic test_reset();
    #3;
    n_vec++;
    if ({busy, done, bcd, ovf, blank, st} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b bcd=%h ovf=%b blank=%b st=%b, expected all 0",
               busy, done, bcd, ovf, blank, st);
    end
    n_vec++;
    if ({busy2, done2, bcd2, ovf2, blank2, st2} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs_small: got bcd=%h st=%b, expected 0", bcd2, st2);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_values(input int n_rand);
    int vals[$] = '{9999, 0, 42, 16383, 1234, 1, 10000};
    int lat;
    logic [15:0] e_bcd;
    logic e_ovf;
    logic [3:0] e_blank;
    for (int i = 0; i < n_rand; i++) vals.push_back(int'($urandom_range(0, 16383)));
    foreach (vals[i]) begin
      run_conv(vals[i], lat);
      model(vals[i], 4, e_bcd, e_ovf, e_blank);
      n_vec++;
      if (lat !== 16) begin
        n_err++;
        $display("FAIL latency(%0d): got %0d cycles, expected 16", vals[i], lat);
      end
      n_vec++;
      if (bcd !== e_bcd || ovf !== e_ovf) begin
        n_err++;
        $display("FAIL result(%0d): got bcd=%h ovf=%b, expected bcd=%h ovf=%b",
                 vals[i], bcd, ovf, e_bcd, e_ovf);
      end
      n_vec++;
      if (blank !== e_blank || busy !== 1'b0) begin
        n_err++;
        $display("FAIL blank_busy(%0d): got blank=%b busy=%b, expected blank=%b busy=0",
                 vals[i], blank, busy, e_blank);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int n_done = 0;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd5000;
    @(negedge clk);
    start  = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_high: got %b, expected 1", busy);
    end
    start  = 1'b1;
    bin_in = 14'd7;
    @(negedge clk);
    start  = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    n_vec++;
    if (n_done !== 1 || bcd !== 16'h5000) begin
      n_err++;
      $display("FAIL busy_ignore: got %0d dones bcd=%h, expected 1 done bcd=5000", n_done, bcd);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int n_done = 0;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd8765;
    @(negedge clk);
    start  = 1'b0;
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, bcd, ovf, blank, st} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got busy=%b done=%b bcd=%h st=%b, expected all 0",
               busy, done, bcd, st);
    end
    repeat (3) begin
      @(negedge clk);
      if (done) n_done++;
    end
    reset_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (done) n_done++;
    end
    n_vec++;
    if (n_done !== 0 || st !== 2'b00) begin
      n_err++;
      $display("FAIL mid_reset_no_done: got %0d dones st=%b, expected 0 dones st=00", n_done, st);
    end
    run_conv(321, lat);
    n_vec++;
    if (bcd !== 16'h0321 || ovf !== 1'b0 || lat !== 16) begin
      n_err++;
      $display("FAIL after_reset(321): got bcd=%h ovf=%b lat=%0d, expected 0321 0 16", bcd, ovf, lat);
    end
  endtask

  task automatic test_small();
    int lat, t1, t2, v;
    logic [15:0] e_bcd;
    logic e_ovf;
    logic [3:0] e_blank;
    run_conv2(255, lat);
    n_vec++;
    if (lat !== 10 || bcd2 !== 12'h255 || ovf2 !== 1'b0) begin
      n_err++;
      $display("FAIL small_255: got lat=%0d bcd=%h ovf=%b, expected 10 255 0", lat, bcd2, ovf2);
    end
    for (int i = 0; i < 6; i++) begin
      v = int'($urandom_range(0, 255));
      run_conv2(v, lat);
      model(v, 3, e_bcd, e_ovf, e_blank);
      n_vec++;
      if (lat !== 10 || bcd2 !== e_bcd[11:0] || ovf2 !== e_ovf || blank2 !== e_blank[2:0]) begin
        n_err++;
        $display("FAIL small(%0d): got lat=%0d bcd=%h blank=%b, expected 10 %h %b",
                 v, lat, bcd2, blank2, e_bcd[11:0], e_blank[2:0]);
      end
    end
    v = int'($urandom_range(100, 255));
    model(v, 3, e_bcd, e_ovf, e_blank);
    @(negedge clk);
    start2 = 1'b1;
    bin2   = 8'(v);
    t1 = -1;
    t2 = -1;
    for (int i = 0; i < 60 && t2 < 0; i++) begin
      @(negedge clk);
      if (done2) begin
        if (t1 < 0) t1 = cyc;
        else        t2 = cyc;
      end
    end
    start2 = 1'b0;
    n_vec++;
    if (t1 < 0 || t2 < 0 || (t2 - t1) !== 11 || bcd2 !== e_bcd[11:0]) begin
      n_err++;
      $display("FAIL back_to_back(%0d): got gap=%0d bcd=%h, expected gap 11 bcd=%h",
               v, t2 - t1, bcd2, e_bcd[11:0]);
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_values(25);
    test_busy_ignore();
    test_reset_mid();
    test_small();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
